ddr_cmd_scheduler: RTL and testbench
====================================

Name: ddr_cmd_scheduler

Overview:
- Sits directly upstream of the DDR4 interface command-pin driver.
- Accepts read/write requests from the controller's transaction queue over a valid/ready handshake.
- Tracks the open row per bank (open-page policy) and emits one DDR command per clock (NOP, ACT, RD, WR or PRE) with bank group, bank, row and column fields.
- Enforces tRCD, tRP, tRAS and tCCD spacing so the command-pin stage only translates levels.

Parameters:
- BG_WIDTH, 2, bank-group address width.
- BA_WIDTH, 2, bank address width (banks = 2^(BG_WIDTH+BA_WIDTH) = 16).
- ROW_WIDTH, 14, row address width.
- COL_WIDTH, 10, column address width.
- T_RCD, 11, minimum cycles from ACT to RD/WR on the same bank.
- T_RP, 11, minimum cycles from PRE to ACT on the same bank.
- T_RAS, 28, minimum cycles from ACT to PRE on the same bank.
- T_CCD, 4, minimum cycles between any two RD/WR commands.

Ports:
- clock_t  in  1  controller clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_rw  in  1  0 = read, 1 = write.
- req_bg  in  BG_WIDTH  target bank group.
- req_ba  in  BA_WIDTH  target bank.
- req_row  in  ROW_WIDTH  target row.
- req_col  in  COL_WIDTH  target column.
- cmd_out  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE.
- cmd_bg  out  BG_WIDTH  bank group of the command.
- cmd_ba  out  BA_WIDTH  bank of the command.
- cmd_row  out  ROW_WIDTH  row (valid on ACT, otherwise 0).
- cmd_col  out  COL_WIDTH  column (valid on RD/WR, otherwise 0).
- busy  out  1  a request is latched and its RD/WR is not yet issued.

Behaviour:
- Clock and reset: one clock, clock_t. Reset is synchronous and active-high.
- Reset state:
  - FSM = IDLE; all bank-open flags cleared; all per-bank counters = 0; tCCD counter = 0.
  - cmd_out = NOP; cmd_bg, cmd_ba, cmd_row and cmd_col = 0.
  - req_ready = 0 during the reset cycle; busy = 0.
- Output register: all cmd_* outputs are registered. Any cycle with no issued command drives NOP with all fields 0.
- Handshake:
  - req_ready = 1 only in IDLE.
  - On acceptance the request is latched and the FSM leaves IDLE.
  - Inputs are ignored when req_ready = 0.
- Per-bank state:
  - open flag plus open_row register.
  - act_cnt: loaded with T_RCD on ACT.
  - ras_cnt: loaded with T_RAS on ACT.
  - rp_cnt: loaded with T_RP on PRE.
  - All counters decrement by 1 per cycle and saturate at 0.
- Global cnt_ccd: loaded with T_CCD on RD/WR.
- Counter rule: a command issued in cycle n loaded with T allows the dependent command no earlier than cycle n+T.
- FSM states: IDLE, CHECK, PRE_WAIT, ACT_ISSUE, RCD_WAIT, RW_ISSUE.
- CHECK, on the latched bank (decided in one cycle):
  - open and open_row == req_row (hit) -> RW_ISSUE.
  - Not open -> ACT_ISSUE.
  - Open with a different row (miss) -> PRE_WAIT.
- PRE_WAIT:
  - Wait until ras_cnt == 0, then issue PRE, clear the open flag, load rp_cnt.
  - Then -> ACT_ISSUE.
- ACT_ISSUE:
  - Wait until rp_cnt == 0, then issue ACT.
  - Set open, open_row = req_row; load act_cnt and ras_cnt.
  - Then -> RCD_WAIT.
- RCD_WAIT: wait until act_cnt == 0 -> RW_ISSUE.
- RW_ISSUE:
  - Wait until cnt_ccd == 0 and act_cnt == 0, then issue RD (req_rw = 0) or WR (req_rw = 1) with req_col.
  - Load cnt_ccd, then -> IDLE.
- Issue rate: at most one non-NOP command per cycle.
- Counters of other banks keep decrementing during any wait.
- busy = 1 from the cycle after acceptance through the cycle RD/WR is issued.
- Boundaries:
  - Back-to-back hits to the same row are limited by T_CCD: RD-to-RD spacing = T_CCD when the next request is presented immediately.
  - Reset asserted mid-sequence (any state) returns to IDLE next cycle and closes all banks. The latched request is dropped and not retried.
  - A counter value of 0 at entry means the command issues in that same state's first cycle.
  - T_* parameters must be >= 1; widths are sized to hold max(T_*).

Test Plan:
- Reset, then read bg=1 ba=2 row=0x0123 col=0x010 to a closed bank.
  - ACT(row 0x0123) issues; RD(col 0x010) exactly 11 cycles later; req_ready returns high the cycle after RD.
- Second read to the same bank/row 0x0123, col 0x020, presented immediately.
  - No ACT or PRE; RD issues at least 4 cycles after the prior RD.
- Write to the same bank, row 0x0456 (miss), right after the first ACT.
  - PRE no earlier than 28 cycles after the ACT; ACT(0x0456) 11 cycles after PRE; WR 11 cycles after that ACT.
- Interleaved requests to bank 0 and bank 5, both closed.
  - Each gets its own ACT; the bank-5 RD respects tCCD after the bank-0 RD; bank-0 open_row is unchanged.
- Assert reset during RCD_WAIT.
  - Next cycle cmd_out = NOP, busy = 0, req_ready = 1.
  - A following request to the same row issues ACT again (bank closed).
- Hold req_valid low for 50 cycles.
  - cmd_out stays NOP with all fields 0; no counter underflows below 0.

Source files
------------

// File: rtl/ddr_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// ddr_cmd_scheduler
//
// Open-page DDR4 command scheduler. Accepts one read/write request at a time
// over a valid/ready handshake, tracks the open row of each bank and emits at
// most one DDR command per clock (NOP/ACT/RD/WR/PRE). tRCD, tRP, tRAS and
// tCCD spacing is enforced here, so the downstream pin driver only has to
// translate levels.
//
// Ports
//   clock_t    in   controller clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request accepted when req_valid && req_ready
//   req_rw     in   0 = read, 1 = write
//   req_bg     in   target bank group
//   req_ba     in   target bank
//   req_row    in   target row
//   req_col    in   target column
//   cmd_out    out  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE (registered)
//   cmd_bg     out  bank group of the command (registered)
//   cmd_ba     out  bank of the command (registered)
//   cmd_row    out  row on ACT, otherwise 0 (registered)
//   cmd_col    out  column on RD/WR, otherwise 0 (registered)
//   busy       out  a request is latched and its RD/WR is not yet issued
// ---------------------------------------------------------------------------
module ddr_cmd_scheduler #(
    parameter int unsigned BG_WIDTH  = 2,
    parameter int unsigned BA_WIDTH  = 2,
    parameter int unsigned ROW_WIDTH = 14,
    parameter int unsigned COL_WIDTH = 10,
    parameter int unsigned T_RCD     = 11,
    parameter int unsigned T_RP      = 11,
    parameter int unsigned T_RAS     = 28,
    parameter int unsigned T_CCD     = 4
) (
    input  logic                 clock_t,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rw,
    input  logic [BG_WIDTH-1:0]  req_bg,
    input  logic [BA_WIDTH-1:0]  req_ba,
    input  logic [ROW_WIDTH-1:0] req_row,
    input  logic [COL_WIDTH-1:0] req_col,
    output logic [2:0]           cmd_out,
    output logic [BG_WIDTH-1:0]  cmd_bg,
    output logic [BA_WIDTH-1:0]  cmd_ba,
    output logic [ROW_WIDTH-1:0] cmd_row,
    output logic [COL_WIDTH-1:0] cmd_col,
    output logic                 busy
);

    // -----------------------------------------------------------------------
    // Sizing
    // -----------------------------------------------------------------------
    localparam int unsigned BANK_W    = BG_WIDTH + BA_WIDTH;
    localparam int unsigned NUM_BANKS = 1 << BANK_W;
    localparam int unsigned T_MAX_A   = (T_RCD > T_RP)  ? T_RCD : T_RP;
    localparam int unsigned T_MAX_B   = (T_RAS > T_CCD) ? T_RAS : T_CCD;
    localparam int unsigned T_MAX     = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned CNT_W     = $clog2(T_MAX + 1);

    // A counter is loaded with T in the issue cycle; that cycle already counts
    // as the first elapsed one, so the register holds T-1 afterwards and the
    // dependent command sees zero exactly T cycles after the issue.
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RAS = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] LD_CCD = CNT_W'(T_CCD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PRE_WAIT,
        S_ACT_ISSUE,
        S_RCD_WAIT,
        S_RW_ISSUE
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                 state_q;
    logic                   lat_rw_q;
    logic [BG_WIDTH-1:0]    lat_bg_q;
    logic [BA_WIDTH-1:0]    lat_ba_q;
    logic [ROW_WIDTH-1:0]   lat_row_q;
    logic [COL_WIDTH-1:0]   lat_col_q;

    logic [NUM_BANKS-1:0]   open_q;
    logic [NUM_BANKS-1:0]   open_d;
    logic [ROW_WIDTH-1:0]   open_row_q [NUM_BANKS];
    logic [ROW_WIDTH-1:0]   open_row_d [NUM_BANKS];
    logic [CNT_W-1:0]       act_cnt_q  [NUM_BANKS];
    logic [CNT_W-1:0]       act_cnt_d  [NUM_BANKS];
    logic [CNT_W-1:0]       ras_cnt_q  [NUM_BANKS];
    logic [CNT_W-1:0]       ras_cnt_d  [NUM_BANKS];
    logic [CNT_W-1:0]       rp_cnt_q   [NUM_BANKS];
    logic [CNT_W-1:0]       rp_cnt_d   [NUM_BANKS];
    logic [CNT_W-1:0]       ccd_cnt_q;
    logic [CNT_W-1:0]       ccd_cnt_d;

    logic [2:0]             cmd_q;
    logic [BG_WIDTH-1:0]    cmd_bg_q;
    logic [BA_WIDTH-1:0]    cmd_ba_q;
    logic [ROW_WIDTH-1:0]   cmd_row_q;
    logic [COL_WIDTH-1:0]   cmd_col_q;
    logic                   busy_q;

    // -----------------------------------------------------------------------
    // Latched-bank view and issue decisions
    // -----------------------------------------------------------------------
    logic [BANK_W-1:0]      lat_bank_c;
    logic [CNT_W-1:0]       sel_act_c;
    logic [CNT_W-1:0]       sel_ras_c;
    logic [CNT_W-1:0]       sel_rp_c;
    logic                   sel_open_c;
    logic                   sel_hit_c;
    logic                   issue_pre_c;
    logic                   issue_act_c;
    logic                   issue_rw_c;

    assign lat_bank_c  = {lat_bg_q, lat_ba_q};
    assign sel_act_c   = act_cnt_q[lat_bank_c];
    assign sel_ras_c   = ras_cnt_q[lat_bank_c];
    assign sel_rp_c    = rp_cnt_q[lat_bank_c];
    assign sel_open_c  = open_q[lat_bank_c];
    assign sel_hit_c   = sel_open_c && (open_row_q[lat_bank_c] == lat_row_q);

    assign issue_pre_c = (state_q == S_PRE_WAIT)  && (sel_ras_c == '0);
    assign issue_act_c = (state_q == S_ACT_ISSUE) && (sel_rp_c == '0);
    assign issue_rw_c  = (state_q == S_RW_ISSUE)  && (ccd_cnt_q == '0) && (sel_act_c == '0);

    // -----------------------------------------------------------------------
    // Bank table and timing counters: free-running saturating decrement,
    // reloaded on the command they guard
    // -----------------------------------------------------------------------
    always_comb begin
        open_d    = open_q;
        ccd_cnt_d = (ccd_cnt_q != '0) ? (ccd_cnt_q - CNT_ONE) : '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            open_row_d[b] = open_row_q[b];
            act_cnt_d[b]  = (act_cnt_q[b] != '0) ? (act_cnt_q[b] - CNT_ONE) : '0;
            ras_cnt_d[b]  = (ras_cnt_q[b] != '0) ? (ras_cnt_q[b] - CNT_ONE) : '0;
            rp_cnt_d[b]   = (rp_cnt_q[b]  != '0) ? (rp_cnt_q[b]  - CNT_ONE) : '0;
        end

        if (issue_pre_c) begin
            open_d[lat_bank_c]   = 1'b0;
            rp_cnt_d[lat_bank_c] = LD_RP;
        end
        if (issue_act_c) begin
            open_d[lat_bank_c]     = 1'b1;
            open_row_d[lat_bank_c] = lat_row_q;
            act_cnt_d[lat_bank_c]  = LD_RCD;
            ras_cnt_d[lat_bank_c]  = LD_RAS;
        end
        if (issue_rw_c) begin
            ccd_cnt_d = LD_CCD;
        end
    end

    always_ff @(posedge clock_t) begin : bank_regs
        if (reset) begin
            open_q    <= '0;
            ccd_cnt_q <= '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                open_row_q[b] <= '0;
                act_cnt_q[b]  <= '0;
                ras_cnt_q[b]  <= '0;
                rp_cnt_q[b]   <= '0;
            end
        end else begin
            open_q    <= open_d;
            ccd_cnt_q <= ccd_cnt_d;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                open_row_q[b] <= open_row_d[b];
                act_cnt_q[b]  <= act_cnt_d[b];
                ras_cnt_q[b]  <= ras_cnt_d[b];
                rp_cnt_q[b]   <= rp_cnt_d[b];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Request FSM with registered command outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clock_t) begin : fsm
        if (reset) begin
            state_q   <= S_IDLE;
            lat_rw_q  <= 1'b0;
            lat_bg_q  <= '0;
            lat_ba_q  <= '0;
            lat_row_q <= '0;
            lat_col_q <= '0;
            cmd_q     <= CMD_NOP;
            cmd_bg_q  <= '0;
            cmd_ba_q  <= '0;
            cmd_row_q <= '0;
            cmd_col_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            // Any cycle without an issued command drives a clean NOP
            cmd_q     <= CMD_NOP;
            cmd_bg_q  <= '0;
            cmd_ba_q  <= '0;
            cmd_row_q <= '0;
            cmd_col_q <= '0;

            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_rw_q  <= req_rw;
                        lat_bg_q  <= req_bg;
                        lat_ba_q  <= req_ba;
                        lat_row_q <= req_row;
                        lat_col_q <= req_col;
                        busy_q    <= 1'b1;
                        state_q   <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (sel_hit_c) begin
                        state_q <= S_RW_ISSUE;
                    end else if (sel_open_c) begin
                        state_q <= S_PRE_WAIT;
                    end else begin
                        state_q <= S_ACT_ISSUE;
                    end
                end

                S_PRE_WAIT: begin
                    if (issue_pre_c) begin
                        cmd_q    <= CMD_PRE;
                        cmd_bg_q <= lat_bg_q;
                        cmd_ba_q <= lat_ba_q;
                        state_q  <= S_ACT_ISSUE;
                    end
                end

                S_ACT_ISSUE: begin
                    if (issue_act_c) begin
                        cmd_q     <= CMD_ACT;
                        cmd_bg_q  <= lat_bg_q;
                        cmd_ba_q  <= lat_ba_q;
                        cmd_row_q <= lat_row_q;
                        state_q   <= S_RCD_WAIT;
                    end
                end

                S_RCD_WAIT: begin
                    // Leave one cycle early so RW_ISSUE sees act_cnt == 0 on
                    // entry and RD/WR lands exactly tRCD after the ACT.
                    if (sel_act_c <= CNT_ONE) begin
                        state_q <= S_RW_ISSUE;
                    end
                end

                S_RW_ISSUE: begin
                    if (issue_rw_c) begin
                        cmd_q     <= lat_rw_q ? CMD_WR : CMD_RD;
                        cmd_bg_q  <= lat_bg_q;
                        cmd_ba_q  <= lat_ba_q;
                        cmd_col_q <= lat_col_q;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Ready is gated by reset so it is low during the reset cycle itself and
    // high in the first cycle after reset releases.
    assign req_ready = (state_q == S_IDLE) && !reset;
    assign cmd_out   = cmd_q;
    assign cmd_bg    = cmd_bg_q;
    assign cmd_ba    = cmd_ba_q;
    assign cmd_row   = cmd_row_q;
    assign cmd_col   = cmd_col_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ddr_cmd_scheduler
//
// Self-checking bench. A transaction-level reference model computes, for each
// accepted request, the clock edge at which every PRE/ACT/RD/WR must appear
// from the timing rules (per-bank last ACT/PRE times, global last RD/WR time)
// and the request's row-hit/closed/miss class. Every cycle the DUT command
// outputs, busy and req_ready are compared with the model.
// ---------------------------------------------------------------------------
module tb_ddr_cmd_scheduler;

    localparam int T_RCD = 11;
    localparam int T_RP  = 11;
    localparam int T_RAS = 28;
    localparam int T_CCD = 4;
    localparam int NEG   = -1000;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_bg;
    logic [1:0]  req_ba;
    logic [13:0] req_row;
    logic [9:0]  req_col;
    logic [2:0]  cmd_out;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [13:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        busy;

    ddr_cmd_scheduler dut (
        .clock_t   (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_bg    (req_bg),
        .req_ba    (req_ba),
        .req_row   (req_row),
        .req_col   (req_col),
        .cmd_out   (cmd_out),
        .cmd_bg    (cmd_bg),
        .cmd_ba    (cmd_ba),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected command event, keyed by the clock edge that launches it
    typedef struct {
        int          e;
        logic [2:0]  c;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [13:0] row;
        logic [9:0]  col;
    } ev_t;

    ev_t         evq[$];
    int          ecnt;
    int          n_checks;
    int          n_pass;
    int          free_edge;
    bit          started;
    bit          accepted;
    bit          open_m   [16];
    logic [13:0] row_m    [16];
    int          last_act [16];
    int          last_pre [16];
    int          last_rw;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, ecnt);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_ev(input int e, input logic [2:0] c, input logic [13:0] row,
                           input logic [9:0] col);
        ev_t ev;
        ev.e   = e;
        ev.c   = c;
        ev.bg  = req_bg;
        ev.ba  = req_ba;
        ev.row = row;
        ev.col = col;
        evq.push_back(ev);
    endtask

    // Reference model: react to the inputs seen at clock edge ecnt
    task automatic model_edge();
        int b;
        int a;
        int pre;
        int act;
        int act_lb;
        int rw;
        if (reset) begin
            evq.delete();
            for (int i = 0; i < 16; i++) begin
                open_m[i]   = 1'b0;
                row_m[i]    = '0;
                last_act[i] = NEG;
                last_pre[i] = NEG;
            end
            last_rw   = NEG;
            free_edge = ecnt;
            started   = 1'b1;
        end else if (started && req_valid && (ecnt - 1 >= free_edge)) begin
            accepted = 1'b1;
            b = int'({req_bg, req_ba});
            a = ecnt;
            if (open_m[b] && row_m[b] == req_row) begin
                rw = max2(a + 2, max2(last_rw + T_CCD, last_act[b] + T_RCD));
            end else begin
                act_lb = a + 2;
                if (open_m[b]) begin
                    pre = max2(a + 2, last_act[b] + T_RAS);
                    push_ev(pre, 3'd4, 14'd0, 10'd0);
                    last_pre[b] = pre;
                    act_lb      = pre + 1;
                end
                act = max2(act_lb, last_pre[b] + T_RP);
                push_ev(act, 3'd1, req_row, 10'd0);
                last_act[b] = act;
                open_m[b]   = 1'b1;
                row_m[b]    = req_row;
                rw = max2(max2(act + T_RCD, act + 2), last_rw + T_CCD);
            end
            push_ev(rw, req_rw ? 3'd3 : 3'd2, 14'd0, req_col);
            last_rw   = rw;
            free_edge = rw;
        end
    endtask

    task automatic compare();
        ev_t ex;
        ex.e = ecnt; ex.c = 3'd0; ex.bg = '0; ex.ba = '0; ex.row = '0; ex.col = '0;
        if (evq.size() > 0 && evq[0].e == ecnt) begin
            ex = evq.pop_front();
        end
        check_eq("cmd_out", 32'(cmd_out), 32'(ex.c));
        check_eq("cmd_bg",  32'(cmd_bg),  32'(ex.bg));
        check_eq("cmd_ba",  32'(cmd_ba),  32'(ex.ba));
        check_eq("cmd_row", 32'(cmd_row), 32'(ex.row));
        check_eq("cmd_col", 32'(cmd_col), 32'(ex.col));
        check_eq("busy",      32'(busy),      32'(ecnt < free_edge));
        check_eq("req_ready", 32'(req_ready), 32'((ecnt >= free_edge) && !reset));
    endtask

    // One clock: inputs already set by the caller
    task automatic tick();
        @(posedge clk);
        ecnt++;
        model_edge();
        #1;
        if (started) compare();
    endtask

    task automatic send(input logic rw, input logic [1:0] bg, input logic [1:0] ba,
                        input logic [13:0] row, input logic [9:0] col);
        req_valid = 1'b1;
        req_rw    = rw;
        req_bg    = bg;
        req_ba    = ba;
        req_row   = row;
        req_col   = col;
        accepted  = 1'b0;
        for (int i = 0; i < 300 && !accepted; i++) tick();
        if (!accepted) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        bit done;
        req_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (ecnt >= free_edge && evq.size() == 0) done = 1'b1;
            else tick();
        end
        if (!done) check_eq("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        ecnt      = 0;
        n_checks  = 0;
        n_pass    = 0;
        free_edge = 0;
        started   = 1'b0;
        accepted  = 1'b0;
        last_rw   = NEG;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_bg    = '0;
        req_ba    = '0;
        req_row   = '0;
        req_col   = '0;

        // Reset: outputs idle, ready low while reset is held
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Closed-bank read, immediate same-row read, then a row miss write
        send(1'b0, 2'd1, 2'd2, 14'h0123, 10'h010);
        send(1'b0, 2'd1, 2'd2, 14'h0123, 10'h020);
        send(1'b1, 2'd1, 2'd2, 14'h0456, 10'h030);
        drain();

        // Interleaved closed banks 0 and 5, then a bank-0 hit on its old row
        send(1'b0, 2'd0, 2'd0, 14'h0111, 10'h005);
        send(1'b0, 2'd1, 2'd1, 14'h0222, 10'h006);
        send(1'b0, 2'd0, 2'd0, 14'h0111, 10'h007);
        drain();

        // Reset while waiting for tRCD; the same row must be re-activated
        send(1'b0, 2'd3, 2'd3, 14'h00aa, 10'h001);
        idle(5);
        pulse_reset();
        idle(1);
        send(1'b0, 2'd3, 2'd3, 14'h00aa, 10'h002);
        drain();

        // Long idle stretch
        idle(50);

        // Randomized traffic over a few banks and rows with occasional resets
        for (int n = 0; n < 250; n++) begin
            logic [13:0] row;
            logic [3:0]  bank;
            bank = 4'($urandom_range(0, 3)) * 4'd5;
            row  = 14'($urandom_range(1, 3)) << 4;
            send(1'($urandom_range(0, 1)), bank[3:2], bank[1:0], row, 10'($urandom_range(0, 1023)));
            if ($urandom_range(0, 59) == 0) begin
                idle(int'($urandom_range(0, 20)));
                pulse_reset();
            end else begin
                idle(int'($urandom_range(0, 2)));
            end
        end
        drain();
        idle(3);
        check_eq("evq_empty", 32'(evq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
